// File: rtl/seg_disp_ctrl_if.sv
// Switch input and display-side outputs of the two-digit seven-segment sequencer.
interface seg_disp_ctrl_if;
  logic       sw;
  logic [6:0] seg_out;
  logic [1:0] dig_en;
  logic [6:0] value;
  logic       busy;

  modport master (
    input  sw,
    output seg_out,
    output dig_en,
    output value,
    output busy
  );

  modport slave (
    output sw,
    input  seg_out,
    input  dig_en,
    input  value,
    input  busy
  );
endinterface

// File: rtl/seg_disp_ctrl.sv
// Two-digit seven-segment sequencer: a debounced press adds STEP to a mod-100 total,
// an iterative subtractor converts it to BCD, and the digits are scanned onto one bus.
module seg_disp_ctrl #(
  parameter int unsigned STEP         = 25,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned SCAN_CYC     = 1000
) (
  input  logic            clk,
  input  logic            reset,
  seg_disp_ctrl_if.master bus
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC);
  localparam int unsigned SCAN_W = $clog2(SCAN_CYC);
  localparam int unsigned VAL_W  = 7;
  localparam int unsigned DIG_W  = 4;
  localparam int unsigned SEG_W  = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DIV,
    S_COMMIT
  } state_t;

  // Input conditioning
  logic            sw_meta;
  logic            sw_sync;
  logic            sw_stable;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  // Arithmetic / conversion
  state_t           state;
  logic             pending;
  logic             busy_q;
  logic [VAL_W-1:0] value_q;
  logic [VAL_W-1:0] rem;
  logic [DIG_W-1:0] tens_w;
  logic [DIG_W-1:0] ones_w;
  logic [DIG_W-1:0] tens_d;
  logic [DIG_W-1:0] ones_d;
  logic [7:0]       sum_c;

  // Scan
  logic [SCAN_W-1:0] scan_cnt;
  logic              sel;
  logic [SEG_W-1:0]  seg_q;
  logic [1:0]        dig_en_q;

  // Active-low segment pattern a..g for one BCD digit; non-decimal codes show "0".
  function automatic logic [SEG_W-1:0] enc(input logic [DIG_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b0000001;
    endcase
    return s;
  endfunction

  // Two-flop synchronizer, then a level must hold DEBOUNCE_CYC cycles to be accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_meta   <= 1'b0;
      sw_sync   <= 1'b0;
      sw_stable <= 1'b0;
      db_cnt    <= '0;
      press     <= 1'b0;
    end else begin
      sw_meta <= bus.sw;
      sw_sync <= sw_meta;
      press   <= 1'b0;
      if (sw_sync != sw_stable) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
          sw_stable <= sw_sync;
          db_cnt    <= '0;
          press     <= sw_sync;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign sum_c = {1'b0, value_q} + 8'(STEP);

  // Add / divide-by-repeated-subtraction / commit sequencer with one queued press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      pending <= 1'b0;
      busy_q  <= 1'b0;
      value_q <= '0;
      rem     <= '0;
      tens_w  <= '0;
      ones_w  <= '0;
      tens_d  <= '0;
      ones_d  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (press || pending) begin
            state   <= S_ADD;
            pending <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_ADD: begin
          if (sum_c >= 8'd100) begin
            value_q <= VAL_W'(sum_c - 8'd100);
            rem     <= VAL_W'(sum_c - 8'd100);
          end else begin
            value_q <= VAL_W'(sum_c);
            rem     <= VAL_W'(sum_c);
          end
          tens_w <= '0;
          state  <= S_DIV;
        end
        S_DIV: begin
          if (rem >= VAL_W'(10)) begin
            rem    <= rem - VAL_W'(10);
            tens_w <= tens_w + DIG_W'(1);
          end else begin
            ones_w <= DIG_W'(rem);
            state  <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          tens_d <= tens_w;
          ones_d <= ones_w;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
      // A press during a conversion is remembered once; further ones are dropped.
      if (state != S_IDLE && press) begin
        pending <= 1'b1;
      end
    end
  end

  // Free-running scan; outputs follow sel one cycle later so ones shows first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      sel      <= 1'b0;
      seg_q    <= 7'b1111111;
      dig_en_q <= 2'b00;
    end else begin
      if (scan_cnt == SCAN_W'(SCAN_CYC - 1)) begin
        scan_cnt <= '0;
        sel      <= ~sel;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
      dig_en_q <= sel ? 2'b10 : 2'b01;
      seg_q    <= enc(sel ? tens_d : ones_d);
    end
  end

  assign bus.seg_out = seg_q;
  assign bus.dig_en  = dig_en_q;
  assign bus.value   = value_q;
  assign bus.busy    = busy_q;

endmodule
